// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone arbiter.
//
// Ports:
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   wbm{0,1}_*_i              master request fields (adr, dat, sel, we, cyc, stb, cti, bte)
//   wbm{0,1}_*_o              master responses (dat, ack, err, rty)
//   wbs_*_o                   shared slave request, driven from the current owner
//   wbs_*_i                   slave response (dat, ack, err, rty)
//   grant_o                   one-hot current owner, 2'b00 when idle
//
// Ownership is granted on a registered edge and held for as long as the
// owner keeps cyc high, so bursts and locked sequences are never split.
// Masters alternate on contention. A watchdog aborts a stalled slave
// access with err after TIMEOUT cycles of stb without a response.
module wb_arbiter2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,

    input  logic [AW-1:0]     wbm0_adr_i,
    input  logic [DW-1:0]     wbm0_dat_i,
    input  logic [DW/8-1:0]   wbm0_sel_i,
    input  logic              wbm0_we_i,
    input  logic              wbm0_cyc_i,
    input  logic              wbm0_stb_i,
    input  logic [2:0]        wbm0_cti_i,
    input  logic [1:0]        wbm0_bte_i,
    output logic [DW-1:0]     wbm0_dat_o,
    output logic              wbm0_ack_o,
    output logic              wbm0_err_o,
    output logic              wbm0_rty_o,

    input  logic [AW-1:0]     wbm1_adr_i,
    input  logic [DW-1:0]     wbm1_dat_i,
    input  logic [DW/8-1:0]   wbm1_sel_i,
    input  logic              wbm1_we_i,
    input  logic              wbm1_cyc_i,
    input  logic              wbm1_stb_i,
    input  logic [2:0]        wbm1_cti_i,
    input  logic [1:0]        wbm1_bte_i,
    output logic [DW-1:0]     wbm1_dat_o,
    output logic              wbm1_ack_o,
    output logic              wbm1_err_o,
    output logic              wbm1_rty_o,

    output logic [AW-1:0]     wbs_adr_o,
    output logic [DW-1:0]     wbs_dat_o,
    output logic [DW/8-1:0]   wbs_sel_o,
    output logic              wbs_we_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic [2:0]        wbs_cti_o,
    output logic [1:0]        wbs_bte_o,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i,
    input  logic              wbs_rty_i,

    output logic [1:0]        grant_o
);

    localparam int unsigned    CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] WdMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

    logic            own_cyc, own_stb;
    logic            slave_resp;
    logic            wd_expire;
    logic            timeout_err;
    logic            pick;

    assign own_cyc    = owner_q ? wbm1_cyc_i : wbm0_cyc_i;
    assign own_stb    = owner_q ? wbm1_stb_i : wbm0_stb_i;
    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // wd_expire depends only on registered state and master inputs so it can
    // gate wbs_cyc_o/stb_o without a path from the slave response. If the
    // slave still answers in that cycle, the response wins and no err is made.
    assign wd_expire   = (state_q == StOwn) && own_cyc && own_stb && (wd_cnt_q == WdMax);
    assign timeout_err = wd_expire && !slave_resp;

    // On contention grant the master that did not win last time.
    assign pick = (wbm0_cyc_i && wbm1_cyc_i) ? ~last_q : wbm1_cyc_i;

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (wbm0_cyc_i || wbm1_cyc_i) begin
                    state_d = StOwn;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            StOwn: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                end else if (timeout_err) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q != StOwn) || !own_stb || slave_resp) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + CntW'(1);
        end
    end

    // Output logic
    always_comb begin
        wbs_adr_o  = '0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbs_we_o   = 1'b0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_cti_o  = '0;
        wbs_bte_o  = '0;
        wbm0_dat_o = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm0_rty_o = 1'b0;
        wbm1_dat_o = '0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        wbm1_rty_o = 1'b0;
        grant_o    = 2'b00;

        if (state_q != StIdle) begin
            grant_o = owner_q ? 2'b10 : 2'b01;
        end

        if (state_q == StOwn) begin
            if (owner_q) begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_we_o   = wbm1_we_i;
                wbs_cyc_o  = wbm1_cyc_i && !wd_expire;
                wbs_stb_o  = wbm1_stb_i && !wd_expire;
                wbs_cti_o  = wbm1_cti_i;
                wbs_bte_o  = wbm1_bte_i;
                wbm1_dat_o = wbs_dat_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i | timeout_err;
                wbm1_rty_o = wbs_rty_i;
            end else begin
                wbs_adr_o  = wbm0_adr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_we_o   = wbm0_we_i;
                wbs_cyc_o  = wbm0_cyc_i && !wd_expire;
                wbs_stb_o  = wbm0_stb_i && !wd_expire;
                wbs_cti_o  = wbm0_cti_i;
                wbs_bte_o  = wbm0_bte_i;
                wbm0_dat_o = wbs_dat_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i | timeout_err;
                wbm0_rty_o = wbs_rty_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk;
    logic          wb_rst_n;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat, m1_dat, s_dat_o, m0_dat_o, m1_dat_o, s_dat_i;
    logic [3:0]    m0_sel, m1_sel, s_sel;
    logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [2:0]    m0_cti, m1_cti, s_cti;
    logic [1:0]    m0_bte, m1_bte, s_bte;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [1:0]    grant;

    int n_vec = 0;
    int n_err = 0;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .wbm0_adr_i (m0_adr),
        .wbm0_dat_i (m0_dat),
        .wbm0_sel_i (m0_sel),
        .wbm0_we_i  (m0_we),
        .wbm0_cyc_i (m0_cyc),
        .wbm0_stb_i (m0_stb),
        .wbm0_cti_i (m0_cti),
        .wbm0_bte_i (m0_bte),
        .wbm0_dat_o (m0_dat_o),
        .wbm0_ack_o (m0_ack),
        .wbm0_err_o (m0_err),
        .wbm0_rty_o (m0_rty),
        .wbm1_adr_i (m1_adr),
        .wbm1_dat_i (m1_dat),
        .wbm1_sel_i (m1_sel),
        .wbm1_we_i  (m1_we),
        .wbm1_cyc_i (m1_cyc),
        .wbm1_stb_i (m1_stb),
        .wbm1_cti_i (m1_cti),
        .wbm1_bte_i (m1_bte),
        .wbm1_dat_o (m1_dat_o),
        .wbm1_ack_o (m1_ack),
        .wbm1_err_o (m1_err),
        .wbm1_rty_o (m1_rty),
        .wbs_adr_o  (s_adr),
        .wbs_dat_o  (s_dat_o),
        .wbs_sel_o  (s_sel),
        .wbs_we_o   (s_we),
        .wbs_cyc_o  (s_cyc),
        .wbs_stb_o  (s_stb),
        .wbs_cti_o  (s_cti),
        .wbs_bte_o  (s_bte),
        .wbs_dat_i  (s_dat_i),
        .wbs_ack_i  (s_ack),
        .wbs_err_i  (s_err),
        .wbs_rty_i  (s_rty),
        .grant_o    (grant)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
        m0_cti = '0; m0_bte = '0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
        m1_cti = '0; m1_bte = '0;
        s_dat_i = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    // All stimulus changes on the falling edge; checks follow #1 later.
    task automatic nedge();
        @(negedge wb_clk);
    endtask

    task automatic do_reset();
        nedge();
        wb_rst_n = 1'b0;
        clear_inputs();
        nedge();
        nedge();
        wb_rst_n = 1'b1;
    endtask

    initial begin
        wb_rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_wbs_cyc", 64'(s_cyc), 64'h0);
        do_reset();

        // Single master write
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h9000_0000;
        m0_dat = 32'hdead_beef; m0_sel = 4'hF;
        #1;
        check("w_idle_cyc", 64'(s_cyc), 64'h0);
        check("w_idle_grant", 64'(grant), 64'h0);
        nedge();
        s_ack = 1;
        #1;
        check("w_grant", 64'(grant), 64'h1);
        check("w_adr", 64'(s_adr), 64'h9000_0000);
        check("w_dat", 64'(s_dat_o), 64'hdead_beef);
        check("w_sel", 64'(s_sel), 64'hF);
        check("w_we", 64'(s_we), 64'h1);
        check("w_cyc", 64'(s_cyc), 64'h1);
        check("w_m0_ack", 64'(m0_ack), 64'h1);
        check("w_m1_ack", 64'(m1_ack), 64'h0);
        nedge();
        s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        nedge();
        #1;
        check("w_release", 64'(grant), 64'h0);

        // Contention and alternation
        do_reset();
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
        nedge();
        s_ack = 1; s_dat_i = 32'hcafe_0001;
        #1;
        check("c_grant0", 64'(grant), 64'h1);
        check("c_adr0", 64'(s_adr), 64'h100);
        check("c_m0_dat", 64'(m0_dat_o), 64'hcafe_0001);
        check("c_m1_dat", 64'(m1_dat_o), 64'h0);
        check("c_m1_ack", 64'(m1_ack), 64'h0);
        nedge();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        nedge();
        #1;
        check("c_idle_gap", 64'(grant), 64'h0);
        nedge();
        s_ack = 1;
        #1;
        check("c_grant1", 64'(grant), 64'h2);
        check("c_adr1", 64'(s_adr), 64'h200);
        check("c_m1_ack1", 64'(m1_ack), 64'h1);
        check("c_m0_ack1", 64'(m0_ack), 64'h0);
        nedge();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        nedge();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        nedge();
        #1;
        check("c_alternate", 64'(grant), 64'h1);

        // Burst lock: m1 4-beat burst while m0 waits
        do_reset();
        nedge();
        m1_cyc = 1; m1_stb = 1; m1_cti = 3'b010; m1_adr = 32'h40;
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nedge();
            m1_adr = 32'h40 + 32'(4 * i);
            m1_cti = (i == 3) ? 3'b111 : 3'b010;
            s_ack  = 1;
            #1;
            check("b_grant", 64'(grant), 64'h2);
            check("b_adr", 64'(s_adr), 64'(32'h40 + 32'(4 * i)));
            check("b_cti", 64'(s_cti), (i == 3) ? 64'h7 : 64'h2);
            check("b_m1_ack", 64'(m1_ack), 64'h1);
            check("b_m0_ack", 64'(m0_ack), 64'h0);
        end
        nedge();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_cti = '0;
        #1;
        check("b_hold", 64'(grant), 64'h2);
        nedge();
        #1;
        check("b_gap", 64'(grant), 64'h0);
        nedge();
        #1;
        check("b_m0_grant", 64'(grant), 64'h1);
        check("b_m0_adr", 64'(s_adr), 64'h80);

        // Watchdog timeout
        do_reset();
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h400;
        for (int k = 1; k <= 8; k++) begin
            nedge();
            #1;
            check("t_m0_err", 64'(m0_err), (k == 8) ? 64'h1 : 64'h0);
            check("t_wbs_cyc", 64'(s_cyc), (k == 8) ? 64'h0 : 64'h1);
        end
        check("t_m1_err", 64'(m1_err), 64'h0);
        nedge();
        #1;
        check("t_abort_err", 64'(m0_err), 64'h0);
        check("t_abort_cyc", 64'(s_cyc), 64'h0);
        check("t_abort_grant", 64'(grant), 64'h1);
        nedge();
        #1;
        check("t_abort_hold", 64'(grant), 64'h1);
        m0_cyc = 0; m0_stb = 0;
        nedge();
        #1;
        check("t_idle", 64'(grant), 64'h0);
        nedge();
        #1;
        check("t_m1_grant", 64'(grant), 64'h2);
        check("t_m1_adr", 64'(s_adr), 64'h400);

        // Ack on the last watchdog cycle wins over timeout
        do_reset();
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
        for (int k = 1; k <= 7; k++) nedge();
        nedge();
        s_ack = 1;
        #1;
        check("l_m0_ack", 64'(m0_ack), 64'h1);
        check("l_m0_err", 64'(m0_err), 64'h0);
        nedge();
        s_ack = 0;
        #1;
        check("l_own_cyc", 64'(s_cyc), 64'h1);
        check("l_own_grant", 64'(grant), 64'h1);
        check("l_no_err", 64'(m0_err), 64'h0);

        // Reset during beat 2 of an m0 burst
        do_reset();
        nedge();
        m0_cyc = 1; m0_stb = 1; m0_cti = 3'b010; m0_adr = 32'h600;
        nedge();
        s_ack = 1; s_dat_i = 32'h1111_2222;
        nedge();
        m0_adr = 32'h604;
        #1;
        check("r_pre_grant", 64'(grant), 64'h1);
        wb_rst_n = 1'b0;
        #1;
        check("r_grant", 64'(grant), 64'h0);
        check("r_wbs_cyc", 64'(s_cyc), 64'h0);
        check("r_wbs_adr", 64'(s_adr), 64'h0);
        check("r_m0_ack", 64'(m0_ack), 64'h0);
        check("r_m0_dat", 64'(m0_dat_o), 64'h0);
        clear_inputs();
        nedge();
        wb_rst_n = 1'b1;
        nedge();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        nedge();
        #1;
        check("r_m0_wins", 64'(grant), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
